uart_rx: RTL

Receive side of the board UART: turns the asynchronous `rxd_i` line into 8-bit bytes and queues them for the CPU-side consumer through a small FIFO with a valid/ready stream. Sits in `main` next to the existing transmitter driving `txd_o`, so firmware and benches can inject commands and test data into the core, not only print from it. Format is fixed 8N1, LSB first.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx_sync_fifo.sv | 53 +++++
 rtl/uart_rx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and state encoding for the board UART receive path.
// Also holds the default bit period used by the transmitter and the top level.
package uart_rx_pkg;

    localparam int unsigned DefClksPerBit = 868;
    localparam int unsigned DefFifoDepth  = 4;
    localparam int unsigned DataW         = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line input plus the byte stream and error pulses of the UART receiver.
// The receiver uses the slave modport; the consumer or bench uses the master modport.
interface uart_rx_if;

    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rxd,
        output ready,
        input  data,
        input  valid,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rxd,
        input  ready,
        output data,
        output valid,
        output frame_err,
        output overrun
    );

endinterface

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock FIFO with registered pointers, shared by the UART transmit and receive paths.
// A pop in the same cycle frees a slot, so a push into a full FIFO is taken when popping.
module uart_rx_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AddrW = $clog2(Depth);

    // Extra pointer bit distinguishes full from empty.
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        do_pop   = pop && !empty;
        push_ok  = push && (!full || do_pop);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pop_data = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and shift register feeding a
// small FIFO that presents bytes as a valid/ready stream, with frame and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned FIFO_DEPTH   = DefFifoDepth
) (
    input logic       clk,
    input logic       rst,
    uart_rx_if.slave  bus
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [DataW-1:0] shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             push;
    logic             push_ok;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DataW-1:0] fifo_data;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b11;
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus.rxd};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                // A start bit that is high again at mid-bit is a glitch.
                if (cnt_q == CntHalf) begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntFull) begin
                    shift_d = {rx_s, shift_q[DataW-1:1]};
                    cnt_d   = '0;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                // Leaving at mid-stop-bit lets an immediately following start bit be caught.
                if (cnt_q == CntFull) begin
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign overrun_d = push && !push_ok;

    uart_rx_sync_fifo #(
        .Width (DataW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_q),
        .push_ok   (push_ok),
        .pop       (bus.ready),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Full is only consulted inside the FIFO; kept visible for debug.
    logic unused_full;
    assign unused_full = fifo_full;

    assign bus.data      = fifo_data;
    assign bus.valid     = !fifo_empty;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule
